// File: rtl/controller.sv
// Instruction field decoder: splits a 32-bit word into format, register,
// function and operand fields, registered with a one-cycle valid qualifier.
module controller (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] in32,
   output logic        out_valid,
   output logic        ri,
   output logic [5:0]  rs,
   output logic [5:0]  rd,
   output logic [3:0]  fx,
   output logic [5:0]  rt,
   output logic [14:0] imm,
   output logic [31:0] imm_sext
);

   logic        dec_ri;
   logic [5:0]  dec_rs;
   logic [5:0]  dec_rd;
   logic [3:0]  dec_fx;
   logic [5:0]  dec_rt;
   logic [14:0] dec_imm;
   logic [31:0] dec_imm_sext;

   always_comb begin
      dec_ri       = in32[31];
      dec_rs       = in32[30:25];
      dec_rd       = in32[24:19];
      dec_fx       = in32[18:15];
      dec_rt       = '0;
      dec_imm      = '0;
      dec_imm_sext = '0;
      // The operand field not used by the current format is forced to zero.
      if (in32[31]) begin
         dec_imm      = in32[14:0];
         dec_imm_sext = {{17{in32[14]}}, in32[14:0]};
      end else begin
         dec_rt       = in32[14:9];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         ri        <= 1'b0;
         rs        <= '0;
         rd        <= '0;
         fx        <= '0;
         rt        <= '0;
         imm       <= '0;
         imm_sext  <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            ri       <= dec_ri;
            rs       <= dec_rs;
            rd       <= dec_rd;
            fx       <= dec_fx;
            rt       <= dec_rt;
            imm      <= dec_imm;
            imm_sext <= dec_imm_sext;
         end
      end
   end

endmodule

// File: tb/tb_controller.sv
// Directed-vector bench for controller: each expected field value is
// hand-decoded from the instruction word.
module tb_controller;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [31:0] in32;
   logic        out_valid;
   logic        ri;
   logic [5:0]  rs;
   logic [5:0]  rd;
   logic [3:0]  fx;
   logic [5:0]  rt;
   logic [14:0] imm;
   logic [31:0] imm_sext;

   int unsigned checks;
   int unsigned failures;

   controller dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in32     (in32),
      .out_valid(out_valid),
      .ri       (ri),
      .rs       (rs),
      .rd       (rd),
      .fx       (fx),
      .rt       (rt),
      .imm      (imm),
      .imm_sext (imm_sext)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic v, input logic f_ri,
                            input logic [5:0] f_rs, input logic [5:0] f_rd,
                            input logic [3:0] f_fx, input logic [5:0] f_rt,
                            input logic [14:0] f_imm, input logic [31:0] f_sext);
      check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
      check({tag, ".ri"},        {31'd0, ri},        {31'd0, f_ri});
      check({tag, ".rs"},        {26'd0, rs},        {26'd0, f_rs});
      check({tag, ".rd"},        {26'd0, rd},        {26'd0, f_rd});
      check({tag, ".fx"},        {28'd0, fx},        {28'd0, f_fx});
      check({tag, ".rt"},        {26'd0, rt},        {26'd0, f_rt});
      check({tag, ".imm"},       {17'd0, imm},       {17'd0, f_imm});
      check({tag, ".imm_sext"},  imm_sext,           f_sext);
   endtask

   task automatic step(input logic r, input logic v, input logic [31:0] w);
      rst      = r;
      in_valid = v;
      in32     = w;
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      in_valid = 1'b0;
      in32     = '0;

      step(1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h0);
      check_all("reset", 1'b0, 1'b0, 6'h00, 6'h00, 4'h0, 6'h00, 15'h0000, 32'h0);

      step(1'b0, 1'b1, 32'hBD547E00);
      check_all("iform", 1'b1, 1'b1, 6'h1E, 6'h2A, 4'h8, 6'h00, 15'h7E00, 32'hFFFFFE00);

      step(1'b0, 1'b1, 32'h7AA87E00);
      check_all("rform", 1'b1, 1'b0, 6'h3D, 6'h15, 4'h0, 6'h3F, 15'h0000, 32'h0);

      step(1'b0, 1'b0, 32'hFFFFFFFF);
      check_all("hold1", 1'b0, 1'b0, 6'h3D, 6'h15, 4'h0, 6'h3F, 15'h0000, 32'h0);
      step(1'b0, 1'b0, 32'hFFFFFFFF);
      check_all("hold2", 1'b0, 1'b0, 6'h3D, 6'h15, 4'h0, 6'h3F, 15'h0000, 32'h0);

      step(1'b0, 1'b1, 32'hBD547E00);
      check_all("b2b_i", 1'b1, 1'b1, 6'h1E, 6'h2A, 4'h8, 6'h00, 15'h7E00, 32'hFFFFFE00);
      step(1'b0, 1'b1, 32'h7AA87E00);
      check_all("b2b_r", 1'b1, 1'b0, 6'h3D, 6'h15, 4'h0, 6'h3F, 15'h0000, 32'h0);
      step(1'b1, 1'b1, 32'hBD547E00);
      check_all("rst_mid", 1'b0, 1'b0, 6'h00, 6'h00, 4'h0, 6'h00, 15'h0000, 32'h0);
      step(1'b0, 1'b0, 32'hBD547E00);
      check_all("post_rst", 1'b0, 1'b0, 6'h00, 6'h00, 4'h0, 6'h00, 15'h0000, 32'h0);

      step(1'b0, 1'b1, 32'h80003FFF);
      check_all("pos_imm", 1'b1, 1'b1, 6'h00, 6'h00, 4'h0, 6'h00, 15'h3FFF, 32'h00003FFF);

      // All-ones I form followed by all-ones R form: stale immediate must clear.
      step(1'b0, 1'b1, 32'hFFFFFFFF);
      check_all("ones_i", 1'b1, 1'b1, 6'h3F, 6'h3F, 4'hF, 6'h00, 15'h7FFF, 32'hFFFFFFFF);
      step(1'b0, 1'b1, 32'h7FFFFFFF);
      check_all("ones_r", 1'b1, 1'b0, 6'h3F, 6'h3F, 4'hF, 6'h3F, 15'h0000, 32'h0);
      step(1'b0, 1'b1, 32'h80004000);
      check_all("neg_min", 1'b1, 1'b1, 6'h00, 6'h00, 4'h0, 6'h00, 15'h4000, 32'hFFFFC000);
      step(1'b0, 1'b1, 32'h00000000);
      check_all("zeros_r", 1'b1, 1'b0, 6'h00, 6'h00, 4'h0, 6'h00, 15'h0000, 32'h0);
      step(1'b0, 1'b1, 32'h02100200);
      check_all("lsb_r", 1'b1, 1'b0, 6'h01, 6'h02, 4'h0, 6'h01, 15'h0000, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
